rv32i_writeback_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 31 +++
 rtl/rv32i_load_align.sv | 34 +++
 rtl/rv32i_writeback_stage.sv | 217 +++++++++++++++++++++
 tb/tb_rv32i_writeback_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared opcode, load-width and FSM-state definitions for the writeback stage.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package rv32i_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rv32i_load_align.sv
// Selects the addressed lanes of a naturally aligned memory word and sign/zero-extends them.
// Latency: purely combinational.
// Backpressure: none; bytes past the end of the word read as zero (no wrap).
module rv32i_load_align
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [XLEN-1:0]            word,
  output logic [XLEN-1:0]            value
);

  logic [XLEN-1:0] shifted;

  // Shift the addressed byte to lane 0, then extend according to the load width.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    value   = '0;
    case (funct3)
      F3_LB:   value = XLEN'($signed(shifted[7:0]));
      F3_LH:   value = XLEN'($signed(shifted[15:0]));
      F3_LW:   value = XLEN'($signed(shifted[31:0]));
      F3_LBU:  value = XLEN'(shifted[7:0]);
      F3_LHU:  value = XLEN'(shifted[15:0]);
      // Doubleword and unsigned-word loads only exist on 64-bit datapaths.
      F3_LWU:  if (XLEN == 64) value = XLEN'(shifted[31:0]);
      F3_LD:   if (XLEN == 64) value = shifted;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_writeback_stage.sv
// Writeback stage: computes rd value / next PC, retires into regfile and fetch; optional WB_MISALIGN_TRAP_EN.
// Latency: accept (or load ack) at cycle N -> registered one-cycle pulses at N+1.
// Backpressure: o_ready drops while a load waits for i_load_ack; i_kill clears everything.
module rv32i_writeback_stage
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_kill,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_alu_out,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_load_data,
  input  logic            i_load_ack,
  output logic            o_wr_rd,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd,
  output logic            o_pc_change,
  output logic [XLEN-1:0] o_pc_new,
  output logic            o_flush,
  output logic [XLEN-1:0] o_pc,
  output logic [63:0]     o_instret
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic            o_trap,
  output logic [XLEN-1:0] o_trap_addr
`endif
);

  localparam int OFFW = $clog2(XLEN / 8);

  wb_state_t state, state_nxt;

  // Fields of a load held while waiting for its data.
  logic [2:0]      lat_funct3;
  logic [4:0]      lat_rd_addr;
  logic [OFFW-1:0] lat_off;
  logic [XLEN-1:0] lat_pc;

  logic            in_wait;
  logic [6:0]      cur_opcode;
  logic [2:0]      cur_funct3;
  logic [4:0]      cur_rd_addr;
  logic [OFFW-1:0] cur_off;
  logic [XLEN-1:0] cur_pc;

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] base, sum, target, pc_plus, rd_val;
  logic            is_load, redirect, rd_we;
  logic            trap_ld, trap_tgt;
  logic            retire, latch_en, trap_fire;

  assign in_wait = (state == WAIT_LOAD);
  assign o_ready = (state == IDLE);
  assign o_flush = o_pc_change;

  // Retire either the arriving instruction or the parked load.
  always_comb begin
    cur_opcode  = in_wait ? OP_LOAD     : i_opcode;
    cur_funct3  = in_wait ? lat_funct3  : i_funct3;
    cur_rd_addr = in_wait ? lat_rd_addr : i_rd_addr;
    cur_off     = in_wait ? lat_off     : i_alu_out[OFFW-1:0];
    cur_pc      = in_wait ? lat_pc      : i_pc;
  end

  rv32i_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (cur_funct3),
    .offset (cur_off),
    .word   (i_load_data),
    .value  (load_val)
  );

  // Shared target adder, rd value selection and write/redirect decode.
  always_comb begin
    is_load  = (cur_opcode == OP_LOAD);
    base     = (cur_opcode == OP_JALR) ? i_rs1 : cur_pc;
    sum      = base + i_imm;
    target   = sum;
    if (cur_opcode == OP_JALR) target[0] = 1'b0;
    pc_plus  = cur_pc + XLEN'(4);
    redirect = (cur_opcode == OP_JAL) || (cur_opcode == OP_JALR) ||
               ((cur_opcode == OP_BRANCH) && i_alu_out[0]);
    rd_we    = (cur_rd_addr != 5'd0) &&
               !(cur_opcode inside {OP_BRANCH, OP_STORE, OP_SYSTEM, OP_FENCE});
    rd_val   = '0;
    case (cur_opcode)
      OP_R_TYPE, OP_I_TYPE: rd_val = i_alu_out;
      OP_LOAD:              rd_val = load_val;
      OP_JAL, OP_JALR:      rd_val = pc_plus;
      OP_LUI:               rd_val = i_imm;
      OP_AUIPC:             rd_val = sum;
      default:              rd_val = '0;
    endcase
  end

`ifdef WB_MISALIGN_TRAP_EN
  logic [XLEN-1:0] trap_addr;

  // Misaligned load addresses are caught at accept, before any wait.
  always_comb begin
    trap_ld = 1'b0;
    if (!in_wait && is_load) begin
      case (i_funct3)
        F3_LH, F3_LHU: trap_ld = i_alu_out[0];
        F3_LW, F3_LWU: trap_ld = |i_alu_out[1:0];
        F3_LD:         trap_ld = |i_alu_out[2:0];
        default:       trap_ld = 1'b0;
      endcase
    end
  end

  assign trap_tgt  = redirect && (target[1:0] != 2'b00);
  assign trap_addr = trap_ld ? i_alu_out : target;
`else
  assign trap_ld  = 1'b0;
  assign trap_tgt = 1'b0;
`endif

  // Next-state and retire/latch/trap decisions; kill overrides all of them.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    latch_en  = 1'b0;
    trap_fire = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (trap_ld || trap_tgt) begin
            trap_fire = 1'b1;
          end else if (is_load && !i_load_ack) begin
            latch_en  = 1'b1;
            state_nxt = WAIT_LOAD;
          end else begin
            retire = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (i_load_ack) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (i_kill) begin
      state_nxt = IDLE;
      retire    = 1'b0;
      latch_en  = 1'b0;
      trap_fire = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Registered retire outputs, architectural PC, retire counter and parked load fields.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wr_rd     <= 1'b0;
      o_rd_addr   <= 5'd0;
      o_rd        <= '0;
      o_pc_change <= 1'b0;
      o_pc_new    <= '0;
      o_pc        <= RESET_PC;
      o_instret   <= 64'd0;
      lat_funct3  <= 3'd0;
      lat_rd_addr <= 5'd0;
      lat_off     <= '0;
      lat_pc      <= '0;
    end else begin
      o_wr_rd     <= retire && rd_we;
      o_pc_change <= retire && redirect;
      if (retire && rd_we) begin
        o_rd_addr <= cur_rd_addr;
        o_rd      <= rd_val;
      end
      if (retire && redirect) o_pc_new <= target;
      if (retire) begin
        o_pc      <= redirect ? target : pc_plus;
        o_instret <= o_instret + 64'd1;
      end
      if (latch_en) begin
        lat_funct3  <= i_funct3;
        lat_rd_addr <= i_rd_addr;
        lat_off     <= i_alu_out[OFFW-1:0];
        lat_pc      <= i_pc;
      end
    end
  end

`ifdef WB_MISALIGN_TRAP_EN
  // One-cycle trap pulse; the offending address holds until the next trap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_trap      <= 1'b0;
      o_trap_addr <= '0;
    end else begin
      o_trap <= trap_fire;
      if (trap_fire) o_trap_addr <= trap_addr;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_writeback_stage.sv
// Bench for rv32i_writeback_stage: directed cases then random traffic against a reference model.
// Latency: model predicts the registered outputs one clock after the inputs are sampled.
// Backpressure: model tracks a pending-load queue to predict o_ready.
`timescale 1ns/1ps
module tb_rv32i_writeback_stage;

  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0080;

  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, SYSTEM = 7'h73, FENCE = 7'h0F;
  localparam logic [6:0] RTYPE = 7'h33, ITYPE = 7'h13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, kill, ack;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic [31:0] alu_out, pc, imm, rs1, load_data;

  logic        ready, wr_rd, pc_change, flush;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd, pc_new, o_pc;
  logic [63:0] instret;
`ifdef WB_MISALIGN_TRAP_EN
  logic        trap;
  logic [31:0] trap_addr;
`endif

  rv32i_writeback_stage #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_kill(kill),
    .i_opcode(opcode), .i_funct3(funct3), .i_rd_addr(rd_addr),
    .i_alu_out(alu_out), .i_pc(pc), .i_imm(imm), .i_rs1(rs1),
    .i_load_data(load_data), .i_load_ack(ack),
    .o_wr_rd(wr_rd), .o_rd_addr(o_rd_addr), .o_rd(o_rd),
    .o_pc_change(pc_change), .o_pc_new(pc_new), .o_flush(flush),
    .o_pc(o_pc), .o_instret(instret)
`ifdef WB_MISALIGN_TRAP_EN
    , .o_trap(trap), .o_trap_addr(trap_addr)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] pc;
  } ld_t;

  ld_t         pend[$];
  logic [31:0] m_pc;
  logic [63:0] m_instret;
  logic        e_wr, e_chg, e_trap;
  logic [4:0]  e_rd_addr;
  logic [31:0] e_rd, e_pc_new, e_trap_addr;

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] w;
    w = word >> (int'(addr[1:0]) * 8);
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd2:    return w;
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ld_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'd1, 3'd5: return addr[0];
      3'd2, 3'd6: return addr[1:0] != 2'd0;
      3'd3:       return addr[2:0] != 3'd0;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_retire(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] ipc, input logic [31:0] im,
                              input logic [31:0] r1, input logic [31:0] ldata);
    logic [31:0] val, tgt;
    bit          redir, we;
    val = 0; tgt = 0; redir = 0;
    case (op)
      RTYPE, ITYPE: val = alu;
      LOAD:         val = load_value(f3, alu, ldata);
      JAL:          begin val = ipc + 4; redir = 1; tgt = ipc + im; end
      JALR:         begin val = ipc + 4; redir = 1; tgt = (r1 + im) & ~32'd1; end
      LUI:          val = im;
      AUIPC:        val = ipc + im;
      BRANCH:       begin redir = alu[0]; tgt = ipc + im; end
      default:      val = 0;
    endcase
`ifdef WB_MISALIGN_TRAP_EN
    if (redir && tgt[1:0] != 2'd0) begin
      e_trap = 1; e_trap_addr = tgt;
      return;
    end
`endif
    we = (rd != 0) && !(op == BRANCH || op == STORE || op == SYSTEM || op == FENCE);
    e_wr = we;
    if (we) begin e_rd = val; e_rd_addr = rd; end
    e_chg = redir;
    if (redir) e_pc_new = tgt;
    m_pc = redir ? tgt : ipc + 4;
    m_instret = m_instret + 1;
  endtask

  // Predict the effect of the clock edge that will sample the current inputs.
  task automatic model_update();
    ld_t p;
    e_wr = 0; e_chg = 0; e_trap = 0;
    if (!rst_n) begin
      pend.delete();
      m_pc = RPC; m_instret = 0;
      e_rd = 0; e_rd_addr = 0; e_pc_new = 0; e_trap_addr = 0;
    end else if (kill) begin
      pend.delete();
    end else if (pend.size() != 0) begin
      if (ack) begin
        p = pend.pop_front();
        model_retire(LOAD, p.f3, p.rd, p.addr, p.pc, 32'd0, 32'd0, load_data);
      end
    end else if (valid) begin
`ifdef WB_MISALIGN_TRAP_EN
      if (opcode == LOAD && ld_misaligned(funct3, alu_out)) begin
        e_trap = 1; e_trap_addr = alu_out;
      end else
`endif
      if (opcode == LOAD && !ack) begin
        p.f3 = funct3; p.rd = rd_addr; p.addr = alu_out; p.pc = pc;
        pend.push_back(p);
      end else begin
        model_retire(opcode, funct3, rd_addr, alu_out, pc, imm, rs1, load_data);
      end
    end
  endtask

  task automatic check_outputs();
    chk("wr_rd", wr_rd, e_wr);
    chk("rd_addr", o_rd_addr, e_rd_addr);
    chk("rd", o_rd, e_rd);
    chk("pc_change", pc_change, e_chg);
    chk("flush", flush, e_chg);
    chk("pc_new", pc_new, e_pc_new);
    chk("pc", o_pc, m_pc);
    chk("instret", instret, m_instret);
    chk("ready", ready, pend.size() == 0);
`ifdef WB_MISALIGN_TRAP_EN
    chk("trap", trap, e_trap);
    chk("trap_addr", trap_addr, e_trap_addr);
`endif
  endtask

  // Inputs are set at a falling edge; the model predicts the rising edge; outputs checked at the next fall.
  task automatic step();
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    rst_n = 1; valid = 0; kill = 0; ack = 0;
    opcode = 0; funct3 = 0; rd_addr = 0;
    alu_out = 0; pc = 0; imm = 0; rs1 = 0; load_data = 0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr);
    idle(); valid = 1; opcode = LOAD; funct3 = f3; rd_addr = rd; alu_out = addr; pc = 32'h300;
  endtask

  logic [6:0]  ops [12] = '{RTYPE, ITYPE, LOAD, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, 7'h7F};
  logic [63:0] saved_instret;

  initial begin
    // Reset state.
    idle(); rst_n = 0; valid = 1; opcode = LOAD;
    step();
    chk("rst_pc", o_pc, RPC);
    chk("rst_instret", instret, 64'd0);
    chk("rst_ready", ready, 1);
    chk("rst_wr", wr_rd, 0);

    // ADDI retire.
    idle(); valid = 1; opcode = ITYPE; rd_addr = 5; alu_out = 32'h1234; pc = 32'h100;
    step();
    chk("addi_wr", wr_rd, 1);
    chk("addi_rd", o_rd, 32'h1234);
    chk("addi_pc", o_pc, 32'h104);
    chk("addi_instret", instret, 64'd1);

    // Taken branch.
    idle(); valid = 1; opcode = BRANCH; rd_addr = 3; pc = 32'h200; imm = 32'hFFFF_FFF0; alu_out = 1;
    step();
    chk("br_change", pc_change, 1);
    chk("br_flush", flush, 1);
    chk("br_target", pc_new, 32'h1F0);
    chk("br_wr", wr_rd, 0);

    // JALR clears bit 0 of the target and links pc+4.
    idle(); valid = 1; opcode = JALR; rd_addr = 1; rs1 = 32'h1001; imm = 4; pc = 32'h40;
    step();
    chk("jalr_target", pc_new, 32'h1004);
    chk("jalr_rd", o_rd, 32'h44);
    chk("jalr_pc", o_pc, 32'h1004);

    // LB at offset 3 with the ack three cycles later; upstream keeps offering an ADDI.
    issue_load(3'd0, 5'd7, 32'h3);
    step();
    chk("lb_ready_c1", ready, 0);
    idle(); valid = 1; opcode = ITYPE; rd_addr = 9; alu_out = 32'hDEAD;
    step();
    chk("lb_ready_c2", ready, 0);
    step();
    chk("lb_ready_c3", ready, 0);
    ack = 1; load_data = 32'h80FF_FFFF;
    step();
    chk("lb_rd", o_rd, 32'hFFFF_FF80);
    chk("lb_rd_addr", o_rd_addr, 5'd7);
    chk("lb_wr", wr_rd, 1);
    chk("lb_ready_after", ready, 1);

    // Kill while waiting, with an ack in the same cycle.
    issue_load(3'd2, 5'd8, 32'h400);
    step();
    saved_instret = m_instret;
    idle(); kill = 1; ack = 1; load_data = 32'h1234_5678;
    step();
    chk("kill_wr", wr_rd, 0);
    chk("kill_ready", ready, 1);
    chk("kill_instret", instret, saved_instret);
    idle(); ack = 1;
    step();
    chk("idle_ack_wr", wr_rd, 0);
    chk("idle_ack_instret", instret, saved_instret);

    // Reset in the middle of a load.
    issue_load(3'd4, 5'd9, 32'h500);
    step();
    idle(); rst_n = 0;
    step();
    chk("rstld_ready", ready, 1);
    chk("rstld_pc", o_pc, RPC);
    chk("rstld_instret", instret, 64'd0);
    chk("rstld_wr", wr_rd, 0);

`ifdef WB_MISALIGN_TRAP_EN
    // Misaligned LW traps at accept.
    idle();
    step();
    saved_instret = m_instret;
    issue_load(3'd2, 5'd4, 32'h102);
    step();
    chk("trap_pulse", trap, 1);
    chk("trap_addr_val", trap_addr, 32'h102);
    chk("trap_wr", wr_rd, 0);
    chk("trap_instret", instret, saved_instret);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      kill      = ($urandom_range(0, 19) == 0);
      valid     = ($urandom_range(0, 3) != 0);
      ack       = ($urandom_range(0, 2) == 0);
      opcode    = ops[$urandom_range(0, 11)];
      funct3    = 3'($urandom_range(0, 7));
      rd_addr   = 5'($urandom_range(0, 31));
      alu_out   = $urandom;
      pc        = $urandom;
      imm       = $urandom;
      rs1       = $urandom;
      load_data = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
